// File: rtl/convertidor_binario_bcd.sv
// convertidor_binario_bcd: 10-bit unsigned binary (0-1023) to four BCD digits.
// Latency: 2 edges (input register, then digit registers); one result per cycle.
// Backpressure: none; free-running pipeline, a new value is accepted every edge.
// Optional build macro BCD_BLANK_LEADING_ZEROS_EN: leading zero digits become 4'hF.
module convertidor_binario_bcd (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] N_Binario,
  output logic [3:0] Millares,
  output logic [3:0] Centenas,
  output logic [3:0] Decenas,
  output logic [3:0] Unidades
);

  // Stage 1 register: binary value being converted.
  logic [9:0]  r_n_reg;

  // Stage 2 registers: the four output digits.
  logic [3:0]  r_millares;
  logic [3:0]  r_centenas;
  logic [3:0]  r_decenas;
  logic [3:0]  r_unidades;

  // Combinational conversion result (upper 16 bits of the 26-bit scratch).
  logic [15:0] w_bcd;

  // Digits after the optional leading-zero blanking.
  logic [3:0]  w_millares;
  logic [3:0]  w_centenas;
  logic [3:0]  w_decenas;
  logic [3:0]  w_unidades;

  // Capture the input value every edge; reset discards the value in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n_reg <= 10'd0;
    end else begin
      r_n_reg <= N_Binario;
    end
  end

  // Shift-add-3 conversion. Only the BCD half of the scratch value is kept:
  // the binary half just feeds one bit per iteration into the units nibble,
  // MSB first, which is exactly what shifting the full scratch word would do.
  always_comb begin
    w_bcd = 16'd0;
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (w_bcd[4*d +: 4] >= 4'd5) begin
          w_bcd[4*d +: 4] = w_bcd[4*d +: 4] + 4'd3;
        end
      end
      w_bcd = {w_bcd[14:0], r_n_reg[9-i]};
    end
  end

  // Map nibbles to digits and optionally blank the leading zeros.
  always_comb begin
    w_millares = w_bcd[15:12];
    w_centenas = w_bcd[11:8];
    w_decenas  = w_bcd[7:4];
    w_unidades = w_bcd[3:0];
`ifdef BCD_BLANK_LEADING_ZEROS_EN
    // A digit is blank only if it and every higher digit are zero;
    // units always stay numeric so zero still shows as a single 0.
    if (w_bcd[15:12] == 4'd0) begin
      w_millares = 4'hF;
      if (w_bcd[11:8] == 4'd0) begin
        w_centenas = 4'hF;
        if (w_bcd[7:4] == 4'd0) begin
          w_decenas = 4'hF;
        end
      end
    end
`else
    // Plain numeric build: all four digits pass through unchanged.
    w_millares = w_bcd[15:12];
`endif
  end

  // Register the converted digits; reset value is numeric zero in both builds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_millares <= 4'd0;
      r_centenas <= 4'd0;
      r_decenas  <= 4'd0;
      r_unidades <= 4'd0;
    end else begin
      r_millares <= w_millares;
      r_centenas <= w_centenas;
      r_decenas  <= w_decenas;
      r_unidades <= w_unidades;
    end
  end

  assign Millares = r_millares;
  assign Centenas = r_centenas;
  assign Decenas  = r_decenas;
  assign Unidades = r_unidades;

endmodule

// File: tb/tb_convertidor_binario_bcd.sv
// Purpose: scoreboard bench for convertidor_binario_bcd against a div/mod reference.
// Latency: checks outputs 2 edges after each input (reset clears to zero).
// Backpressure: none; one stimulus per edge, bounded waits guard against hangs.
module tb_convertidor_binario_bcd;

    logic       clk;
    logic       reset;
    logic [9:0] N_Binario;
    logic [3:0] Millares;
    logic [3:0] Centenas;
    logic [3:0] Decenas;
    logic [3:0] Unidades;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic [9:0] val;
    } stim_t;

    stim_t sb_q[$];

    convertidor_binario_bcd dut (
        .clk       (clk),
        .reset     (reset),
        .N_Binario (N_Binario),
        .Millares  (Millares),
        .Centenas  (Centenas),
        .Decenas   (Decenas),
        .Unidades  (Unidades)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_conv(input int v);
        logic [3:0] m, c, d, u;
        m = 4'(v / 1000);
        c = 4'((v / 100) % 10);
        d = 4'((v / 10) % 10);
        u = 4'(v % 10);
`ifdef BCD_BLANK_LEADING_ZEROS_EN
        if (v < 1000) m = 4'hF;
        if (v < 100)  c = 4'hF;
        if (v < 10)   d = 4'hF;
`endif
        return {m, c, d, u};
    endfunction

    task automatic apply(input logic [9:0] v, input logic r);
        stim_t e;
        @(negedge clk);
        N_Binario = v;
        reset     = r;
        e.rst = r;
        e.val = v;
        sb_q.push_back(e);
    endtask

    initial begin
        stim_t       cur;
        stim_t       prev;
        bit          have_prev;
        logic [15:0] exp_d;
        logic [15:0] act_d;
        have_prev = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() != 0) begin
                cur = sb_q.pop_front();
                if (cur.rst || have_prev) begin
                    if (cur.rst)       exp_d = 16'h0000;
                    else if (prev.rst) exp_d = ref_conv(0);
                    else               exp_d = ref_conv(int'(prev.val));
                    act_d = {Millares, Centenas, Decenas, Unidades};
                    checks++;
                    if (act_d !== exp_d) begin
                        failures++;
                        $display("FAIL digits: prev_in=%0d prev_rst=%0b rst=%0b got=%h required=%h",
                                 prev.val, prev.rst, cur.rst, act_d, exp_d);
                    end
                end
                prev      = cur;
                have_prev = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        checks++;
        failures++;
        $display("FAIL timeout: stimulus did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int dir_vals[4] = '{1011, 1023, 6, 17};
        int bnd_vals[7] = '{0, 9, 10, 99, 100, 999, 1000};
        stim_t e0;
        bit    drained;
        reset     = 1'b1;
        N_Binario = 10'd1011;
        e0.rst = 1'b1;
        e0.val = 10'd1011;
        sb_q.push_back(e0);
        apply(10'd1011, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if ({Millares, Centenas, Decenas, Unidades} !== 16'h0000) begin
            failures++;
            $display("FAIL reset state: got=%h required=0000",
                     {Millares, Centenas, Decenas, Unidades});
        end
        for (int i = 0; i < 3; i++) apply(10'd1011, 1'b0);
        foreach (dir_vals[i]) apply(10'(dir_vals[i]), 1'b0);
        foreach (bnd_vals[i]) apply(10'(bnd_vals[i]), 1'b0);
        for (int v = 0; v < 1024; v++) apply(10'(v), 1'b0);
        apply(10'd1023, 1'b0);
        apply(10'd1023, 1'b1);
        apply(10'd1023, 1'b0);
        apply(10'd17, 1'b0);
        apply(10'd6, 1'b0);
        for (int i = 0; i < 600; i++) begin
            apply(10'($urandom_range(0, 1023)), ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 4; i++) apply(10'd999, 1'b0);
        for (int i = 0; i < 3; i++) apply(10'd0, 1'b0);
        drained = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #4;
            if (sb_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        checks++;
        if (!drained) begin
            failures++;
            $display("FAIL wait expired: scoreboard still holds %0d entries", sb_q.size());
        end
        repeat (2) @(posedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
